// File: rtl/ext_mem_master_if.sv
// Host command/response and external memory bus bundle for ext_mem_master.
// The master modport is the bridge's view; slave is the host+memory side.
interface ext_mem_master_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, mem_rdata, mem_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ext_mem_master.sv
// Single-outstanding bridge from a valid/ready host port to a strobe/ack
// external memory, with an ack timeout that turns into an error response.
module ext_mem_master #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  ext_mem_master_if.master  bus
);
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TMO_CYC);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_t            state_q, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              idle_q, idle_d;
  logic              mem_req_q, mem_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      idle_q      <= 1'b1;
      mem_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      mem_req_q   <= mem_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    mem_req_d   = mem_req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = REQ;
          idle_d    = 1'b0;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          cmd_d     = '{we: bus.cmd_we, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        end
      end
      REQ, WAIT: begin
        mem_req_d = 1'b0;
        // Ack is checked first so an ack landing on the timeout cycle wins.
        if (bus.mem_ack) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = cmd_q.we ? '0 : bus.mem_rdata;
        end else if (state_q == REQ) begin
          state_d = WAIT;
        end else if (cnt_inc == TMO) begin
          state_d     = RESP;
          cnt_d       = cnt_inc;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          idle_d      = 1'b1;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // idle_q resets to 1 so cmd_ready is up right after release; the rst_n
  // gate keeps it low while reset is held.
  assign bus.cmd_ready = idle_q & rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
endmodule

// File: tb/tb_ext_mem_master.sv
// Directed bench for ext_mem_master with a short timeout (TMO_CYC=4).
module tb_ext_mem_master;
  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   rsp_cnt = 0;
  int   r0, p0;

  ext_mem_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ext_mem_master #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_req) req_cnt <= req_cnt + 1;
    if (bus.rsp_valid && bus.rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_bus",   32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();

    // Write 0x7FF/0xBEEF, ack in first WAIT cycle
    r0 = req_cnt;
    send(1'b1, 11'h7FF, 16'hBEEF);
    tick();
    bus.cmd_valid = 1'b0;
    chk("wr_mem_req",   32'(bus.mem_req),   32'd1);
    chk("wr_mem_we",    32'(bus.mem_we),    32'd1);
    chk("wr_mem_addr",  32'(bus.mem_addr),  32'h7FF);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    chk("wr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    chk("wr_wait_req",  32'(bus.mem_req),   32'd0);
    chk("wr_wait_addr", 32'(bus.mem_addr),  32'h7FF);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_ack = 1'b0;
    chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("wr_req_pulses", 32'(req_cnt - r0), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("wr_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("wr_done_ready", 32'(bus.cmd_ready), 32'd1);

    // Read 0x123 with ack in the REQ cycle: zero-wait memory
    send(1'b0, 11'h123, 16'h0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("rd0_mem_we",   32'(bus.mem_we),    32'd0);
    chk("rd0_mem_addr", 32'(bus.mem_addr),  32'h123);
    chk("rd0_not_yet",  32'(bus.rsp_valid), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
    tick();
    bus.mem_ack = 1'b0;
    chk("rd0_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd0_rsp_rdata", 32'(bus.rsp_rdata), 32'h5A5A);
    chk("rd0_rsp_err",   32'(bus.rsp_err),   32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Read with no ack: timeout after 4 WAIT cycles, then spurious ack and a held response
    send(1'b0, 11'h055, 16'h0);
    bus.mem_rdata = 16'hFFFF;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    repeat (3) tick();
    chk("tmo_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("tmo_rsp_err",   32'(bus.rsp_err),   32'd1);
    chk("tmo_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_valid", 32'(bus.rsp_valid), 32'd1);
    chk("late_ack_err",   32'(bus.rsp_err),   32'd1);
    chk("late_ack_rdata", 32'(bus.rsp_rdata), 32'd0);
    r0 = req_cnt;
    send(1'b1, 11'h3AA, 16'hCAFE);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_err",   32'(bus.rsp_err),   32'd1);
      chk("hold_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk("hold_no_req", 32'(req_cnt - r0), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hold_release", 32'(bus.rsp_valid), 32'd0);

    // Ack on the same cycle the timeout would fire: ack wins
    send(1'b0, 11'h066, 16'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    repeat (3) tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0A0A;
    tick();
    bus.mem_ack = 1'b0;
    chk("race_valid", 32'(bus.rsp_valid), 32'd1);
    chk("race_err",   32'(bus.rsp_err),   32'd0);
    chk("race_rdata", 32'(bus.rsp_rdata), 32'h0A0A);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during WAIT abandons the write, then a fresh read completes
    p0 = rsp_cnt;
    send(1'b1, 11'h2AA, 16'h1357);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(bus.mem_req),   32'd0);
    chk("mid_rst_bus",   32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    send(1'b0, 11'h010, 16'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0F0F;
    tick();
    bus.mem_ack = 1'b0;
    chk("fresh_valid", 32'(bus.rsp_valid), 32'd1);
    chk("fresh_rdata", 32'(bus.rsp_rdata), 32'h0F0F);
    bus.rsp_ready = 1'b1;
    tick();
    chk("fresh_one_rsp", 32'(rsp_cnt - p0), 32'd1);

    // Back-to-back reads, rsp_ready held high, ack in first WAIT cycle
    r0 = req_cnt;
    p0 = rsp_cnt;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, AW'(11'h100 + i), 16'h0);
      tick();
      bus.cmd_valid = 1'b0;
      chk("b2b_addr", 32'(bus.mem_addr), 32'h100 + 32'(i));
      tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = DW'(16'hA000 + i);
      tick();
      bus.mem_ack = 1'b0;
      chk("b2b_rdata", 32'(bus.rsp_rdata), 32'hA000 + 32'(i));
      tick();
      chk("b2b_idle", 32'(bus.cmd_ready), 32'd1);
    end
    chk("b2b_reqs", 32'(req_cnt - r0), 32'd3);
    chk("b2b_rsps", 32'(rsp_cnt - p0), 32'd3);
    bus.rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
